// File: rtl/barrel_shift_pipelined.sv
// Pipelined barrel shifter: LSL / LSR / ROL / ASR with per-stage radix-2^RADIX_BITS muxing and valid/ready flow control.
// Optional feature: define BARREL_SHIFT_ROTATE_EN to enable rotate-left (mode 10); otherwise mode 10 acts as logical left.
module barrel_shift_pipelined #(
  parameter int unsigned WIDTH      = 13,
  parameter int unsigned RADIX_BITS = 2,
  parameter int unsigned SHIFT_W    = $clog2(WIDTH),
  parameter int unsigned STAGES     = (SHIFT_W + RADIX_BITS - 1) / RADIX_BITS,
  parameter int unsigned TAG_WIDTH  = 8
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [WIDTH-1:0]     in,
  input  logic [SHIFT_W-1:0]   shift,
  input  logic [1:0]           mode,
  input  logic [TAG_WIDTH-1:0] tagIn,
  input  logic                 validIn,
  output logic                 readyIn,
  output logic [WIDTH-1:0]     out,
  output logic [TAG_WIDTH-1:0] tagOut,
  output logic                 validOut,
  input  logic                 readyOut
);

  localparam int unsigned RADIX = 1 << RADIX_BITS;
  localparam int unsigned REM_W = STAGES * RADIX_BITS;

  typedef enum logic [1:0] {
    MODE_LSL = 2'b00,
    MODE_LSR = 2'b01,
    MODE_ROL = 2'b10,
    MODE_ASR = 2'b11
  } mode_e;

  // Shift/rotate by a constant amount; amounts >= WIDTH flush to the fill value.
  function automatic logic [WIDTH-1:0] shift_by(
    input logic [WIDTH-1:0] data,
    input int unsigned      amt,
    input mode_e            md,
    input logic             sign
  );
    logic [WIDTH-1:0] ones;
    logic [WIDTH-1:0] res;
`ifdef BARREL_SHIFT_ROTATE_EN
    int unsigned      rot;
`endif
    ones = '1;
    case (md)
      MODE_LSR: res = data >> amt;
      MODE_ASR: res = (data >> amt) | (sign ? ~(ones >> amt) : '0);
`ifdef BARREL_SHIFT_ROTATE_EN
      MODE_ROL: begin
        rot = amt % WIDTH;
        res = (data << rot) | (data >> (WIDTH - rot));
      end
`endif
      default:  res = data << amt;
    endcase
    return res;
  endfunction

  logic [STAGES:0] stage_ready;

  assign stage_ready[STAGES] = readyOut;

  for (genvar s = 0; s < STAGES; s++) begin : g_stage
    // Remaining shift bits narrow by RADIX_BITS per stage so no stage carries unused bits.
    localparam int unsigned RW = RADIX_BITS * (STAGES - s);

    logic [WIDTH-1:0]     d_in;
    logic [RW-1:0]        r_in;
    mode_e                m_in;
    logic                 sg_in;
    logic [TAG_WIDTH-1:0] t_in;
    logic                 v_in;
    logic [WIDTH-1:0]     shifted;

    logic [WIDTH-1:0]     data_q;
    logic [TAG_WIDTH-1:0] tag_q;
    logic                 valid_q;

    if (s == 0) begin : g_head
      always_comb begin
        d_in  = in;
        r_in  = RW'(shift);
        m_in  = mode_e'(mode);
        sg_in = in[WIDTH-1];
        t_in  = tagIn;
        v_in  = validIn;
      end
    end else begin : g_body
      always_comb begin
        d_in  = g_stage[s-1].data_q;
        r_in  = g_stage[s-1].g_fwd.rem_q;
        m_in  = g_stage[s-1].g_fwd.mode_q;
        sg_in = g_stage[s-1].g_fwd.sign_q;
        t_in  = g_stage[s-1].tag_q;
        v_in  = g_stage[s-1].valid_q;
      end
    end

    assign stage_ready[s] = !valid_q || stage_ready[s+1];

    always_comb begin
      shifted = d_in;
      for (int unsigned d = 0; d < RADIX; d++) begin
        if (int'(r_in[RADIX_BITS-1:0]) == int'(d)) begin
          shifted = shift_by(d_in, d << (s * RADIX_BITS), m_in, sg_in);
        end
      end
    end

    always_ff @(posedge clk) begin
      if (reset) begin
        valid_q <= 1'b0;
        data_q  <= '0;
        tag_q   <= '0;
      end else if (stage_ready[s]) begin
        valid_q <= v_in;
        data_q  <= shifted;
        tag_q   <= t_in;
      end
    end

    // Side fields only matter to downstream stages, so the final stage omits them.
    if (s < STAGES - 1) begin : g_fwd
      logic [RW-RADIX_BITS-1:0] rem_q;
      mode_e                    mode_q;
      logic                     sign_q;

      always_ff @(posedge clk) begin
        if (reset) begin
          rem_q  <= '0;
          mode_q <= MODE_LSL;
          sign_q <= 1'b0;
        end else if (stage_ready[s]) begin
          rem_q  <= r_in[RW-1:RADIX_BITS];
          mode_q <= m_in;
          sign_q <= sg_in;
        end
      end
    end
  end

  assign readyIn  = stage_ready[0] && !reset;
  assign out      = g_stage[STAGES-1].data_q;
  assign tagOut   = g_stage[STAGES-1].tag_q;
  assign validOut = g_stage[STAGES-1].valid_q;

endmodule
